// File: rtl/seg7_capture.sv
// Seven-segment bus monitor: decodes a multiplexed active-low segment bus back to digits
// and delivers a full frame with a single-cycle valid pulse.
module seg7_capture #(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   output logic [4*NUM_DIGITS-1:0] value_out,
   output logic                    frame_valid,
   output logic                    frame_err,
   output logic                    busy
);
   // state  | meaning
   // WAIT   | inputs just changed or dig_sel invalid; looking for a repeat
   // SETTLE | same pattern seen for cnt cycles; counting towards STABLE_CYCLES
   // LOCKED | this dwell already captured; wait for the bus to move on
   typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_LOCKED} state_t;

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   state_t                  state, state_d;
   logic [CW-1:0]           cnt, cnt_d;
   logic [7:0]              prev_seg;
   logic [NUM_DIGITS-1:0]   prev_sel;
   logic [NUM_DIGITS-1:0]   mask, mask_d;
   logic [4*NUM_DIGITS-1:0] stage_val;
   logic [NUM_DIGITS-1:0]   stage_err;
   logic                    same_in, sel_ok, capture, mask_full;
   logic [4:0]              dec;

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h40:   decode = 5'h00;
         7'h79:   decode = 5'h01;
         7'h24:   decode = 5'h02;
         7'h30:   decode = 5'h03;
         7'h19:   decode = 5'h04;
         7'h12:   decode = 5'h05;
         7'h02:   decode = 5'h06;
         7'h78:   decode = 5'h07;
         7'h00:   decode = 5'h08;
         7'h10:   decode = 5'h09;
         default: decode = 5'h1F;
      endcase
   endfunction

   assign dec       = decode(seg_in[6:0]);
   assign same_in   = (seg_in == prev_seg) && (dig_sel == prev_sel);
   assign sel_ok    = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);
   assign mask_full = &mask;

   // cnt holds the number of stable cycles up to the previous cycle, so the
   // capture fires during the STABLE_CYCLES-th cycle of a dwell.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      capture = 1'b0;
      case (state)
         S_WAIT: begin
            cnt_d = '0;
            if (sel_ok && same_in) begin
               if (STABLE_CYCLES <= 2) begin
                  capture = 1'b1;
                  state_d = S_LOCKED;
               end else begin
                  state_d = S_SETTLE;
                  cnt_d   = CW'(2);
               end
            end
         end
         S_SETTLE: begin
            if (!sel_ok || !same_in) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               capture = 1'b1;
               state_d = S_LOCKED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         S_LOCKED: begin
            if (!same_in) state_d = S_WAIT;
         end
         default: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Completion clears the mask, but a same-cycle capture still lands in it.
   assign mask_d = (mask_full ? '0 : mask) | (capture ? dig_sel : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_WAIT;
         cnt         <= '0;
         prev_seg    <= '0;
         prev_sel    <= '0;
         mask        <= '0;
         busy        <= 1'b0;
         stage_val   <= '0;
         stage_err   <= '0;
         value_out   <= '0;
         frame_err   <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         prev_seg    <= seg_in;
         prev_sel    <= dig_sel;
         mask        <= mask_d;
         busy        <= |mask_d;
         frame_valid <= mask_full;
         if (mask_full) begin
            value_out <= stage_val;
            frame_err <= |stage_err;
         end
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (capture && dig_sel[k]) begin
               stage_val[4*k +: 4] <= dec[3:0];
               stage_err[k]        <= dec[4];
            end
         end
      end
   end
endmodule
